// File: rtl/entropy_token_decoder_mc.sv
// rtl/entropy_token_decoder_mc.sv - multi-channel (run,size,magnitude) token to signed coefficient decoder
// Optional macro DC_SATURATE_EN: clamp DC prediction sums instead of wrapping them.
module entropy_token_decoder_mc #(
  parameter int MAG_W        = 11,
  parameter int NUM_CH       = 3,
  parameter int DELTA_DECODE = 1,
  localparam int SIZE_W = $clog2(MAG_W + 1),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              restart_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [MAG_W-1:0]  value_in,
  input  logic [SIZE_W-1:0] size_in,
  input  logic [3:0]        run_in,
  input  logic              dc_in,
  input  logic [CH_W-1:0]   ch_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [MAG_W:0]    value_out,
  output logic [3:0]        run_out,
  output logic [5:0]        pos_out,
  output logic [CH_W-1:0]   ch_out,
  output logic              eob_out,
  output logic              err_out
);
  localparam int VW    = MAG_W + 1;
  localparam int NPRED = 1 << CH_W;
  localparam logic [VW-1:0] ONE_V = VW'(1);

  logic [VW-1:0]     pred_q [NPRED];
  logic [6:0]        pos_q;

  logic              accept;
  logic              ch_ok;
  logic              is_dc;
  logic              is_eob;
  logic [SIZE_W-1:0] size_eff;
  logic [VW-1:0]     pow;
  logic [VW-1:0]     ext;
  logic              sign_bit;
  logic [VW-1:0]     decoded;
  logic [VW-1:0]     pred_base;
  logic [VW-1:0]     dc_sum;
  logic [VW-1:0]     dc_val;
  logic [VW-1:0]     val_next;
  logic [6:0]        pos_base;
  logic [6:0]        ac_target;
  logic [6:0]        ac_next;
  logic [6:0]        pos_tgt;
  logic [6:0]        pos_next;
  logic              pos_ovf;
  logic              err_set;

  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out;

  // Magnitude decode: top meaningful bit clear means a negative value offset by 2^size - 1.
  always_comb begin
    size_eff = (int'(size_in) > MAG_W) ? SIZE_W'(MAG_W) : size_in;
    pow      = ONE_V << size_eff;
    ext      = {1'b0, value_in} & (pow - ONE_V);
    sign_bit = |(ext & (pow >> 1));
    if (size_eff == '0) begin
      decoded = '0;
    end else if (sign_bit) begin
      decoded = ext;
    end else begin
      decoded = ext - pow + ONE_V;
    end
  end

  // A restart in the same cycle as a token clears state before that token is decoded.
  always_comb begin
    ch_ok     = int'(ch_in) < NUM_CH;
    is_dc     = dc_in & ch_ok;
    is_eob    = ~is_dc && (run_in == 4'd0) && (size_in == '0);
    pred_base = (restart_in || !ch_ok) ? '0 : pred_q[ch_in];
    pos_base  = restart_in ? 7'd0 : pos_q;
  end

`ifdef DC_SATURATE_EN
  logic [VW:0] sum_x;
  always_comb begin
    sum_x = {decoded[VW-1], decoded} + {pred_base[VW-1], pred_base};
    if (sum_x[VW] != sum_x[VW-1]) begin
      dc_sum = sum_x[VW] ? {1'b1, {MAG_W{1'b0}}} : {1'b0, {MAG_W{1'b1}}};
    end else begin
      dc_sum = sum_x[VW-1:0];
    end
  end
`else
  always_comb begin
    dc_sum = decoded + pred_base;
  end
`endif

  always_comb begin
    dc_val    = (DELTA_DECODE != 0) ? dc_sum : decoded;
    val_next  = is_dc ? dc_val : decoded;
    ac_target = pos_base + {3'b000, run_in};
    ac_next   = ac_target + 7'd1;
    if (is_dc) begin
      pos_tgt  = 7'd0;
      pos_next = 7'd1;
    end else if (is_eob) begin
      pos_tgt  = pos_base;
      pos_next = 7'd0;
    end else begin
      pos_tgt  = ac_target;
      pos_next = (ac_next > 7'd64) ? 7'd64 : ac_next;
    end
    pos_ovf = pos_tgt[6];
    err_set = pos_ovf | ~ch_ok;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      value_out <= '0;
      run_out   <= '0;
      pos_out   <= '0;
      ch_out    <= '0;
      eob_out   <= 1'b0;
      err_out   <= 1'b0;
      pos_q     <= '0;
      for (int i = 0; i < NPRED; i++) pred_q[i] <= '0;
    end else begin
      if (ready_out) begin
        valid_out <= valid_in;
        if (accept) begin
          value_out <= val_next;
          run_out   <= run_in;
          pos_out   <= pos_ovf ? 6'd63 : pos_tgt[5:0];
          ch_out    <= ch_in;
          eob_out   <= is_eob;
        end
      end
      if (restart_in) begin
        pos_q   <= '0;
        err_out <= 1'b0;
        for (int i = 0; i < NPRED; i++) pred_q[i] <= '0;
      end
      // The accepted token's own updates land after any restart clear.
      if (accept) begin
        pos_q <= pos_next;
        if (err_set) err_out <= 1'b1;
        if (is_dc && (DELTA_DECODE != 0)) pred_q[ch_in] <= dc_val;
      end
    end
  end

endmodule

// File: tb/tb_entropy_token_decoder_mc.sv
// tb/tb_entropy_token_decoder_mc.sv - scoreboard bench for entropy_token_decoder_mc
// Follows DC_SATURATE_EN in its reference model when the macro is defined.
module tb_entropy_token_decoder_mc;
  localparam int MAG_W  = 11;
  localparam int NUM_CH = 3;
  localparam int SIZE_W = 4;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              restart_in = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [MAG_W-1:0]  value_in = '0;
  logic [SIZE_W-1:0] size_in = '0;
  logic [3:0]        run_in = '0;
  logic              dc_in = 1'b0;
  logic [CH_W-1:0]   ch_in = '0;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic [MAG_W:0]    value_out;
  logic [3:0]        run_out;
  logic [5:0]        pos_out;
  logic [CH_W-1:0]   ch_out;
  logic              eob_out;
  logic              err_out;

  entropy_token_decoder_mc #(.MAG_W(MAG_W), .NUM_CH(NUM_CH), .DELTA_DECODE(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .restart_in(restart_in),
    .valid_in(valid_in), .ready_out(ready_out), .value_in(value_in),
    .size_in(size_in), .run_in(run_in), .dc_in(dc_in), .ch_in(ch_in),
    .valid_out(valid_out), .ready_in(ready_in), .value_out(value_out),
    .run_out(run_out), .pos_out(pos_out), .ch_out(ch_out),
    .eob_out(eob_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int value;
    int run;
    int pos;
    int ch;
    bit eob;
    bit err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_pred[NUM_CH];
  int   m_pos = 0;
  bit   m_err = 1'b0;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  function automatic int mag_decode(int v, int s);
    int m;
    if (s == 0) return 0;
    m = v % (1 << s);
    if (((m >> (s - 1)) & 1) == 1) return m;
    return m - (1 << s) + 1;
  endfunction

  function automatic int dc_combine(int x);
`ifdef DC_SATURATE_EN
    if (x > (1 << MAG_W) - 1) x = (1 << MAG_W) - 1;
    if (x < -(1 << MAG_W)) x = -(1 << MAG_W);
    return x;
`else
    int m;
    m = 1 << (MAG_W + 1);
    x = ((x % m) + m) % m;
    if (x >= m / 2) x -= m;
    return x;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) m_pred[i] = 0;
    m_pos = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_token(bit rst, bit dc, int ch, int run, int size, int value);
    exp_t e;
    int   d;
    int   p;
    bit   ch_ok;
    if (rst) model_reset();
    d     = mag_decode(value, size);
    ch_ok = ch < NUM_CH;
    e.run = run;
    e.ch  = ch;
    e.eob = 1'b0;
    if (dc && ch_ok) begin
      e.value    = dc_combine(d + m_pred[ch]);
      m_pred[ch] = e.value;
      p          = 0;
      m_pos      = 1;
    end else if (run == 0 && size == 0) begin
      e.value = 0;
      e.eob   = 1'b1;
      p       = m_pos;
      m_pos   = 0;
    end else begin
      e.value = d;
      p       = m_pos + run;
      m_pos   = (p + 1 > 64) ? 64 : p + 1;
    end
    if (p > 63) begin
      p     = 63;
      m_err = 1'b1;
    end
    if (!ch_ok) m_err = 1'b1;
    e.pos = p;
    e.err = m_err;
    q.push_back(e);
  endfunction

  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("value_out", int'($signed(value_out)), e.value);
        chk("run_out", int'(run_out), e.run);
        chk("pos_out", int'(pos_out), e.pos);
        chk("ch_out", int'(ch_out), e.ch);
        chk("eob_out", int'(eob_out), int'(e.eob));
        chk("err_out", int'(err_out), int'(e.err));
      end
    end
  end

  // Starts and ends at posedge+1; a restart always rides on an accepted token.
  task automatic send(input bit dc, input int ch, input int run, input int size,
                      input int value, input bit rst, input bit stall);
    bit done;
    done       = 1'b0;
    valid_in   = 1'b1;
    dc_in      = dc;
    ch_in      = ch[CH_W-1:0];
    run_in     = run[3:0];
    size_in    = size[SIZE_W-1:0];
    value_in   = value[MAG_W-1:0];
    restart_in = rst;
    for (int i = 0; i < 100 && !done; i++) begin
      ready_in = (rst || !stall) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      if (ready_out) begin
        model_token(rst, dc, ch, run, size, value);
        done = 1'b1;
      end
      @(posedge clk_in);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    valid_in   = 1'b0;
    restart_in = 1'b0;
  endtask

  initial begin
    logic [MAG_W:0] held;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("reset_valid_out", int'(valid_out), 0);
    chk("reset_ready_out", int'(ready_out), 1);
    chk("reset_err_out", int'(err_out), 0);
    chk("reset_value_out", int'(value_out), 0);
    chk("reset_pos_out", int'(pos_out), 0);
    @(posedge clk_in);
    #1;

    // T1
    send(1, 0, 0, 2, 3, 0, 0);
    send(1, 0, 0, 1, 0, 0, 0);
    send(0, 0, 2, 3, 2, 0, 0);
    // T2
    send(1, 0, 0, 2, 3, 1, 0);
    send(1, 1, 0, 3, 5, 0, 0);
    send(1, 0, 0, 0, 0, 0, 0);
    // T3
    send(1, 2, 0, 1, 1, 0, 0);
    send(0, 2, 15, 0, 0, 0, 0);
    send(0, 2, 0, 1, 1, 0, 0);
    send(0, 2, 0, 0, 0, 0, 0);

    // T4: hold token A while B waits
    send(1, 1, 0, 4, 9, 0, 0);
    ready_in = 1'b0;
    valid_in = 1'b1;
    dc_in    = 1'b0;
    ch_in    = 2'd1;
    run_in   = 4'd1;
    size_in  = 4'd2;
    value_in = 11'd1;
    @(negedge clk_in);
    held = value_out;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid_out", int'(valid_out), 1);
      chk("stall_ready_out", int'(ready_out), 0);
      chk("stall_value_held", int'(value_out), int'(held));
      @(posedge clk_in);
      #1;
      @(negedge clk_in);
    end
    @(posedge clk_in);
    #1 ready_in = 1'b1;
    @(negedge clk_in);
    chk("stall_release_ready", int'(ready_out), 1);
    if (ready_out) model_token(0, 0, 1, 1, 2, 1);
    @(posedge clk_in);
    #1 valid_in = 1'b0;

    // T5
    send(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 15, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0, 1, 0);
    // T6
    send(1, 0, 0, 11, 2047, 1, 0);
    send(1, 0, 0, 1, 1, 0, 0);
    // invalid channel
    send(0, 3, 0, 2, 2, 1, 0);

    // Random traffic with backpressure
    for (int n = 0; n < 400; n++) begin
      bit dc;
      int ch;
      int size;
      dc   = ($urandom_range(0, 7) == 0);
      ch   = $urandom_range(0, NUM_CH - 1);
      if (!dc && $urandom_range(0, 31) == 0) ch = 3;
      size = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, MAG_W);
      send(dc, ch, $urandom_range(0, 15), size, $urandom_range(0, (1 << MAG_W) - 1),
           ($urandom_range(0, 39) == 0), 1);
    end

    ready_in = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk_in);
    #1;
    chk("drain_queue_empty", q.size(), 0);

    // Asynchronous reset while a token is held drops it
    send(1, 2, 0, 3, 6, 0, 0);
    ready_in = 1'b0;
    @(negedge clk_in);
    chk("pre_reset_valid", int'(valid_out), 1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("midreset_valid_out", int'(valid_out), 0);
    chk("midreset_err_out", int'(err_out), 0);
    q.delete();
    model_reset();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    send(1, 2, 0, 0, 0, 0, 0);
    ready_in = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_in);
    #1;
    chk("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
